// File: rtl/fifo_piso_drain_pkg.sv
// Shared types and helpers for the FIFO parallel-in/serial-out drain stage.
package fifo_piso_drain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter width never collapses to zero bits, even for single-chunk words.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/fifo_piso_chunk_ctr.sv
// Wrapping chunk counter 0..els_p-1 with clear priority over enable.
module fifo_piso_chunk_ctr
  import fifo_piso_drain_pkg::*;
#(
  parameter int els_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic last_o
);

  localparam int cnt_width_lp = safe_clog2(els_p);
  localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(els_p - 1);

  logic [cnt_width_lp-1:0] cnt_q;

  // With els_p==1 the count is pinned at zero, so last_o is a constant one.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == cnt_max_lp) ? '0 : cnt_q + cnt_width_lp'(1);
    end
  end

  assign last_o = (cnt_q == cnt_max_lp);

endmodule

// File: rtl/fifo_piso_drain.sv
// Drains wide FIFO words (valid/yumi) into LSB-first narrow chunks on a valid/ready link.
module fifo_piso_drain
  import fifo_piso_drain_pkg::*;
#(
  parameter int out_width_p = 8,
  parameter int els_p       = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  input  logic [els_p*out_width_p-1:0] data_i,
  output logic                         yumi_o,
  output logic                         v_o,
  output logic [out_width_p-1:0]       data_o,
  output logic                         last_o,
  input  logic                         ready_i
);

  localparam int width_lp = els_p * out_width_p;

  state_e              state_q, state_n;
  logic [width_lp-1:0] shift_q;
  logic                ctr_last;
  logic                xfer;

  assign v_o    = (state_q == SHIFT);
  assign data_o = shift_q[out_width_p-1:0];
  assign last_o = v_o & ctr_last;
  assign xfer   = v_o & ready_i;
  // A new word is taken when empty or as the final chunk leaves, giving zero-bubble reload.
  assign yumi_o = reset_i & v_i & ((state_q == IDLE) | (xfer & last_o));

  fifo_piso_chunk_ctr #(
    .els_p(els_p)
  ) ctr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(yumi_o),
    .en_i   (xfer & ~last_o),
    .last_o (ctr_last)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    if (yumi_o) begin
      state_n = SHIFT;
    end else if (xfer & last_o) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      shift_q <= '0;
    end else if (yumi_o) begin
      shift_q <= data_i;
    end else if (xfer & ~last_o) begin
      shift_q <= shift_q >> out_width_p;
    end
  end

endmodule

// File: tb/tb_fifo_piso_drain.sv
// Scoreboard bench for fifo_piso_drain: a 8x4 instance and a 16x1 instance.
module tb_fifo_piso_drain;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } item_t;

  logic clk;
  logic rst_n;

  logic        v_a, yumi_a, v_oa, last_oa, ready_a;
  logic [31:0] data_a;
  logic [7:0]  data_oa;

  logic        v_b, yumi_b, v_ob, last_ob, ready_b;
  logic [15:0] data_b;
  logic [15:0] data_ob;

  item_t qa[$];
  item_t qb[$];
  int    total  = 0;
  int    passed = 0;
  int    fails  = 0;

  fifo_piso_drain #(.out_width_p(8), .els_p(4)) dut_a (
    .clk_i  (clk),
    .reset_i(rst_n),
    .v_i    (v_a),
    .data_i (data_a),
    .yumi_o (yumi_a),
    .v_o    (v_oa),
    .data_o (data_oa),
    .last_o (last_oa),
    .ready_i(ready_a)
  );

  fifo_piso_drain #(.out_width_p(16), .els_p(1)) dut_b (
    .clk_i  (clk),
    .reset_i(rst_n),
    .v_i    (v_b),
    .data_i (data_b),
    .yumi_o (yumi_b),
    .v_o    (v_ob),
    .data_o (data_ob),
    .last_o (last_ob),
    .ready_i(ready_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word_a(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      item_t it;
      it.data = 16'(w[i*8 +: 8]);
      it.last = (i == 3);
      qa.push_back(it);
    end
  endtask

  // Drive one cycle on instance A, then compare against the scoreboard head.
  task automatic step_a(input logic v, input logic [31:0] d, input logic rdy, input logic exp_yumi);
    @(negedge clk);
    v_a = v; data_a = d; ready_a = rdy;
    #1;
    check("yumi_a", 32'(yumi_a), 32'(exp_yumi));
    check("v_a", 32'(v_oa), 32'(qa.size() != 0));
    if (qa.size() != 0) begin
      check("data_a", 32'(data_oa), 32'(qa[0].data));
      check("last_a", 32'(last_oa), 32'(qa[0].last));
      if (rdy) void'(qa.pop_front());
    end
    if (exp_yumi) push_word_a(d);
  endtask

  task automatic step_b(input logic v, input logic [15:0] d, input logic rdy, input logic exp_yumi);
    @(negedge clk);
    v_b = v; data_b = d; ready_b = rdy;
    #1;
    check("yumi_b", 32'(yumi_b), 32'(exp_yumi));
    check("v_b", 32'(v_ob), 32'(qb.size() != 0));
    if (qb.size() != 0) begin
      check("data_b", 32'(data_ob), 32'(qb[0].data));
      check("last_b", 32'(last_ob), 32'(qb[0].last));
      if (rdy) void'(qb.pop_front());
    end
    if (exp_yumi) begin
      item_t it;
      it.data = d;
      it.last = 1'b1;
      qb.push_back(it);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v_a = 1'b1; data_a = 32'hFFFF_FFFF; ready_a = 1'b1;
    v_b = 1'b1; data_b = 16'hFFFF;      ready_b = 1'b1;

    // Reset held with valid upstream data: everything stays quiet.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("rst_v_a", 32'(v_oa), 32'd0);
      check("rst_data_a", 32'(data_oa), 32'd0);
      check("rst_last_a", 32'(last_oa), 32'd0);
      check("rst_yumi_a", 32'(yumi_a), 32'd0);
      check("rst_yumi_b", 32'(yumi_b), 32'd0);
      check("rst_v_b", 32'(v_ob), 32'd0);
    end
    @(negedge clk);
    v_a = 1'b0; v_b = 1'b0;
    rst_n = 1'b1;

    // Single word.
    step_a(1'b1, 32'hA1B2_C3D4, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) step_a(1'b0, 32'h0, 1'b1, 1'b0);

    // Back-to-back words with upstream valid held.
    step_a(1'b1, 32'h0302_0100, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) step_a(1'b1, 32'h0706_0504, 1'b1, 1'b0);
    step_a(1'b1, 32'h0706_0504, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) step_a(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure on cycles 2-4 holds C3.
    step_a(1'b1, 32'hA1B2_C3D4, 1'b1, 1'b1);
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) step_a(1'b0, 32'h0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) step_a(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset in the middle of a word.
    step_a(1'b1, 32'hA1B2_C3D4, 1'b1, 1'b1);
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_v_a", 32'(v_oa), 32'd0);
    check("midrst_data_a", 32'(data_oa), 32'd0);
    check("midrst_last_a", 32'(last_oa), 32'd0);
    qa.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
    step_a(1'b1, 32'h1122_3344, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) step_a(1'b0, 32'h0, 1'b1, 1'b0);

    // Single-chunk instance acts as a full-rate pipeline register.
    step_b(1'b1, 16'h1234, 1'b1, 1'b1);
    step_b(1'b1, 16'h5678, 1'b1, 1'b1);
    step_b(1'b0, 16'h0, 1'b1, 1'b0);
    step_b(1'b0, 16'h0, 1'b1, 1'b0);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
